// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Finite-state controller for the multicycle CPU datapath. It decodes the
// opcode/funct fields held in the instruction register and sequences one
// instruction phase per clock. It drives every datapath control line, stalls
// on the memory-ready handshake, and reports halt, illegal-opcode and
// retired-instruction status.
//
// Ports
//   clk          in   system clock, all state updates on the rising edge
//   reset        in   synchronous active-high reset
//   opcode[5:0]  in   instruction register bits [31:26]
//   funct[5:0]   in   instruction register bits [5:0] (only [3:0] used)
//   mem_ready    in   memory access completes in this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, ALUSrcA, RegWrite, RegDst      out  datapath strobes/selects
//   PCSource[1:0], ALUSrcB[1:0]              out  datapath mux selects
//   ALUOp[3:0]                               out  ALU operation
//   state[3:0]   out  current state (debug)
//   halted       out  high while in HALTST
//   illegal_op   out  one-cycle pulse in DECODE on an unknown opcode
//   instr_done   out  one-cycle pulse in the last state of an instruction
//   instr_count  out  number of retired instructions (wraps)
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             opcode,
  input  logic [5:0]             funct,
  input  logic                   mem_ready,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   MemtoReg,
  output logic                   ALUSrcA,
  output logic                   RegWrite,
  output logic                   RegDst,
  output logic [1:0]             PCSource,
  output logic [1:0]             ALUSrcB,
  output logic [3:0]             ALUOp,
  output logic [3:0]             state,
  output logic                   halted,
  output logic                   illegal_op,
  output logic                   instr_done,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_ZEXT = 2'b11;

  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  state_t                   r_state;
  logic [COUNT_WIDTH-1:0]   r_count;

  state_t                   w_state_next;
  logic                     w_pcwrite;
  logic                     w_pcwritecond;
  logic                     w_iord;
  logic                     w_memread;
  logic                     w_memwrite;
  logic                     w_irwrite;
  logic                     w_memtoreg;
  logic                     w_alusrca;
  logic                     w_regwrite;
  logic                     w_regdst;
  logic [1:0]               w_pcsource;
  logic [1:0]               w_alusrcb;
  logic [3:0]               w_aluop;
  logic                     w_halted;
  logic                     w_illegal;
  logic                     w_done;

  // funct[5:4] carry no meaning for this ALU; kept visible to avoid a
  // dangling-input warning.
  logic                     w_unused_funct;
  assign w_unused_funct = ^funct[5:4];

  // Next-state and control decode. Strobes default to 0 so every state only
  // names the lines it drives.
  always_comb begin
    w_state_next  = r_state;
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    w_iord        = 1'b0;
    w_memread     = 1'b0;
    w_memwrite    = 1'b0;
    w_irwrite     = 1'b0;
    w_memtoreg    = 1'b0;
    w_alusrca     = 1'b0;
    w_regwrite    = 1'b0;
    w_regdst      = 1'b0;
    w_pcsource    = 2'b00;
    w_alusrcb     = 2'b00;
    w_aluop       = 4'b0000;
    w_halted      = 1'b0;
    w_illegal     = 1'b0;
    w_done        = 1'b0;

    case (r_state)
      S_FETCH: begin
        // PC+1 is computed every cycle; PC and IR only capture it on the
        // cycle memory delivers the instruction.
        w_memread = 1'b1;
        w_alusrcb = SRCB_ONE;
        w_aluop   = ALU_ADD;
        if (mem_ready) begin
          w_irwrite    = 1'b1;
          w_pcwrite    = 1'b1;
          w_state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch target precomputed into ALUOut while decoding.
        w_alusrcb = SRCB_SEXT;
        w_aluop   = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW:               w_state_next = S_MEMADR;
          OP_RTYPE:                   w_state_next = S_REXEC;
          OP_ADDI, OP_ANDI, OP_ORI:   w_state_next = S_IEXEC;
          OP_BEQ:                     w_state_next = S_BRANCH;
          OP_J:                       w_state_next = S_JUMP;
          OP_HALT:                    w_state_next = S_HALT;
          default: begin
            w_illegal    = 1'b1;
            w_state_next = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = SRCB_SEXT;
        w_aluop   = ALU_ADD;
        if (opcode == OP_LW) begin
          w_state_next = S_MEMRD;
        end else if (opcode == OP_SW) begin
          w_state_next = S_MEMWR;
        end else begin
          w_state_next = S_FETCH;
        end
      end

      S_MEMRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
        if (mem_ready) begin
          w_state_next = S_MEMWB;
        end
      end

      S_MEMWB: begin
        w_memtoreg   = 1'b1;
        w_regwrite   = 1'b1;
        w_done       = 1'b1;
        w_state_next = S_FETCH;
      end

      S_MEMWR: begin
        // MemWrite is held for the whole stall; the store retires on the
        // cycle memory accepts it.
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
        if (mem_ready) begin
          w_done       = 1'b1;
          w_state_next = S_FETCH;
        end
      end

      S_REXEC: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = SRCB_B;
        w_aluop      = funct[3:0];
        w_state_next = S_RWB;
      end

      S_RWB: begin
        w_regdst     = 1'b1;
        w_regwrite   = 1'b1;
        w_done       = 1'b1;
        w_state_next = S_FETCH;
      end

      S_BRANCH: begin
        w_alusrca     = 1'b1;
        w_aluop       = ALU_SUB;
        w_pcwritecond = 1'b1;
        w_pcsource    = PCS_ALUOUT;
        w_done        = 1'b1;
        w_state_next  = S_FETCH;
      end

      S_JUMP: begin
        w_pcwrite    = 1'b1;
        w_pcsource   = PCS_JUMP;
        w_done       = 1'b1;
        w_state_next = S_FETCH;
      end

      S_IEXEC: begin
        w_alusrca = 1'b1;
        case (opcode)
          OP_ANDI: begin
            w_alusrcb = SRCB_ZEXT;
            w_aluop   = ALU_AND;
          end
          OP_ORI: begin
            w_alusrcb = SRCB_ZEXT;
            w_aluop   = ALU_OR;
          end
          default: begin
            w_alusrcb = SRCB_SEXT;
            w_aluop   = ALU_ADD;
          end
        endcase
        w_state_next = S_IWB;
      end

      S_IWB: begin
        w_regwrite   = 1'b1;
        w_done       = 1'b1;
        w_state_next = S_FETCH;
      end

      S_HALT: begin
        w_halted     = 1'b1;
        w_state_next = S_HALT;
      end

      default: begin
        // Unused encodings recover to FETCH with every strobe low.
        w_state_next = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_done) begin
        r_count <= r_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  // Reset gates every output combinationally so an in-flight store is
  // dropped in the very cycle reset rises, not one clock later.
  assign PCWrite     = w_pcwrite     & ~reset;
  assign PCWriteCond = w_pcwritecond & ~reset;
  assign IorD        = w_iord        & ~reset;
  assign MemRead     = w_memread     & ~reset;
  assign MemWrite    = w_memwrite    & ~reset;
  assign IRWrite     = w_irwrite     & ~reset;
  assign MemtoReg    = w_memtoreg    & ~reset;
  assign ALUSrcA     = w_alusrca     & ~reset;
  assign RegWrite    = w_regwrite    & ~reset;
  assign RegDst      = w_regdst      & ~reset;
  assign PCSource    = reset ? 2'b00 : w_pcsource;
  assign ALUSrcB     = reset ? 2'b00 : w_alusrcb;
  assign ALUOp       = reset ? 4'b0000 : w_aluop;
  assign state       = reset ? 4'd0 : r_state;
  assign halted      = w_halted      & ~reset;
  assign illegal_op  = w_illegal     & ~reset;
  assign instr_done  = w_done        & ~reset;
  assign instr_count = reset ? '0 : r_count;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench for multicycle_control. Each step drives the inputs for one
// clock, pushes the expected state/control/count for that cycle into a
// scoreboard queue, pops it mid-cycle and compares against the DUT.
// Control lines are compared as one packed vector in the order:
//   PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg ALUSrcA
//   RegWrite RegDst PCSource[1:0] ALUSrcB[1:0] ALUOp[3:0] halted
//   illegal_op instr_done
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, ALUSrcA, RegWrite, RegDst;
  logic [1:0]  PCSource, ALUSrcB;
  logic [3:0]  ALUOp, state;
  logic        halted, illegal_op, instr_done;
  logic [31:0] instr_count;

  multicycle_control #(.COUNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .state(state), .halted(halted),
    .illegal_op(illegal_op), .instr_done(instr_done),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control-vector bit positions
  localparam logic [20:0] PCW  = 21'd1 << 20;
  localparam logic [20:0] PCWC = 21'd1 << 19;
  localparam logic [20:0] IORD = 21'd1 << 18;
  localparam logic [20:0] MRD  = 21'd1 << 17;
  localparam logic [20:0] MWR  = 21'd1 << 16;
  localparam logic [20:0] IRW  = 21'd1 << 15;
  localparam logic [20:0] M2R  = 21'd1 << 14;
  localparam logic [20:0] ASA  = 21'd1 << 13;
  localparam logic [20:0] RW   = 21'd1 << 12;
  localparam logic [20:0] RD   = 21'd1 << 11;
  localparam logic [20:0] PS_ALUOUT = 21'd1 << 9;
  localparam logic [20:0] PS_JUMP   = 21'd2 << 9;
  localparam logic [20:0] SB_ONE    = 21'd1 << 7;
  localparam logic [20:0] SB_SEXT   = 21'd2 << 7;
  localparam logic [20:0] SB_ZEXT   = 21'd3 << 7;
  localparam logic [20:0] AO_AND    = 21'd0;
  localparam logic [20:0] AO_OR     = 21'd1 << 3;
  localparam logic [20:0] AO_ADD    = 21'd2 << 3;
  localparam logic [20:0] AO_SUB    = 21'd6 << 3;
  localparam logic [20:0] HLT  = 21'd1 << 2;
  localparam logic [20:0] ILL  = 21'd1 << 1;
  localparam logic [20:0] DONE = 21'd1;

  // Expected control vectors per phase, written from the state table
  localparam logic [20:0] K_NONE   = 21'd0;
  localparam logic [20:0] K_FWAIT  = MRD | SB_ONE | AO_ADD;
  localparam logic [20:0] K_FGO    = MRD | SB_ONE | AO_ADD | IRW | PCW;
  localparam logic [20:0] K_DEC    = SB_SEXT | AO_ADD;
  localparam logic [20:0] K_DECILL = SB_SEXT | AO_ADD | ILL;
  localparam logic [20:0] K_MADR   = ASA | SB_SEXT | AO_ADD;
  localparam logic [20:0] K_MRD    = MRD | IORD;
  localparam logic [20:0] K_MWB    = M2R | RW | DONE;
  localparam logic [20:0] K_MWWAIT = MWR | IORD;
  localparam logic [20:0] K_MWGO   = MWR | IORD | DONE;
  localparam logic [20:0] K_REX_SUB = ASA | (21'd6 << 3);
  localparam logic [20:0] K_RWB    = RD | RW | DONE;
  localparam logic [20:0] K_BR     = ASA | AO_SUB | PCWC | PS_ALUOUT | DONE;
  localparam logic [20:0] K_JMP    = PCW | PS_JUMP | DONE;
  localparam logic [20:0] K_IADDI  = ASA | SB_SEXT | AO_ADD;
  localparam logic [20:0] K_IANDI  = ASA | SB_ZEXT | AO_AND;
  localparam logic [20:0] K_IORI   = ASA | SB_ZEXT | AO_OR;
  localparam logic [20:0] K_IWB    = RW | DONE;
  localparam logic [20:0] K_HALT   = HLT;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_BAD  = 6'b010101;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [20:0] ctrl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks;
  int          n_errors;
  logic [31:0] exp_cnt;

  task automatic step(input logic rst_v, input logic rdy_v,
                      input logic [5:0] op_v, input logic [5:0] fn_v,
                      input logic [3:0] est, input logic [20:0] ectrl,
                      input string tag);
    exp_t        e;
    exp_t        got;
    logic [20:0] obs;
    reset     = rst_v;
    mem_ready = rdy_v;
    opcode    = op_v;
    funct     = fn_v;
    e.tag  = tag;
    e.st   = est;
    e.ctrl = ectrl;
    e.cnt  = rst_v ? 32'd0 : exp_cnt;
    sb_q.push_back(e);
    @(negedge clk);
    got = sb_q.pop_front();
    obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, halted,
           illegal_op, instr_done};
    n_checks++;
    assert (state === got.st) else begin
      n_errors++;
      $error("FAIL %s.state observed=%0d expected=%0d", got.tag, state, got.st);
    end
    n_checks++;
    assert (obs === got.ctrl) else begin
      n_errors++;
      $error("FAIL %s.ctrl observed=%b expected=%b", got.tag, obs, got.ctrl);
    end
    n_checks++;
    assert (instr_count === got.cnt) else begin
      n_errors++;
      $error("FAIL %s.count observed=%0d expected=%0d", got.tag, instr_count, got.cnt);
    end
    $display("step %-12s rst=%0b rdy=%0b op=%b state=%0d ctrl=%b count=%0d",
             got.tag, rst_v, rdy_v, op_v, state, obs, instr_count);
    if (rst_v) exp_cnt = 32'd0;
    else if (ectrl[0]) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_cnt   = 32'd0;
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = OP_ADDI;
    funct     = 6'd0;
    @(posedge clk);
    #1;

    // Reset: everything low, including state and count
    step(1, 1, OP_ADDI, 6'd0, 4'd0, K_NONE, "rst0");
    step(1, 0, OP_SW,   6'd0, 4'd0, K_NONE, "rst1");

    // ADDI, mem_ready ignored in IEXEC
    step(0, 1, OP_ADDI, 6'd0, 4'd0,  K_FGO,   "addi.fetch");
    step(0, 1, OP_ADDI, 6'd0, 4'd1,  K_DEC,   "addi.dec");
    step(0, 0, OP_ADDI, 6'd0, 4'd10, K_IADDI, "addi.exec");
    step(0, 1, OP_ADDI, 6'd0, 4'd11, K_IWB,   "addi.wb");

    // LW with two stall cycles in MEMRD (7 cycles total)
    step(0, 1, OP_LW, 6'd0, 4'd0, K_FGO,  "lw.fetch");
    step(0, 1, OP_LW, 6'd0, 4'd1, K_DEC,  "lw.dec");
    step(0, 0, OP_LW, 6'd0, 4'd2, K_MADR, "lw.adr");
    step(0, 0, OP_LW, 6'd0, 4'd3, K_MRD,  "lw.rd0");
    step(0, 0, OP_LW, 6'd0, 4'd3, K_MRD,  "lw.rd1");
    step(0, 1, OP_LW, 6'd0, 4'd3, K_MRD,  "lw.rd2");
    step(0, 0, OP_LW, 6'd0, 4'd4, K_MWB,  "lw.wb");

    // FETCH stalled three cycles, then ORI
    step(0, 0, OP_ORI, 6'd0, 4'd0,  K_FWAIT, "ori.fw0");
    step(0, 0, OP_ORI, 6'd0, 4'd0,  K_FWAIT, "ori.fw1");
    step(0, 0, OP_ORI, 6'd0, 4'd0,  K_FWAIT, "ori.fw2");
    step(0, 1, OP_ORI, 6'd0, 4'd0,  K_FGO,   "ori.fetch");
    step(0, 0, OP_ORI, 6'd0, 4'd1,  K_DEC,   "ori.dec");
    step(0, 1, OP_ORI, 6'd0, 4'd10, K_IORI,  "ori.exec");
    step(0, 1, OP_ORI, 6'd0, 4'd11, K_IWB,   "ori.wb");

    // R-type SUB, BEQ, J
    step(0, 1, OP_R, 6'b000110, 4'd0, K_FGO,     "r.fetch");
    step(0, 1, OP_R, 6'b000110, 4'd1, K_DEC,     "r.dec");
    step(0, 1, OP_R, 6'b000110, 4'd6, K_REX_SUB, "r.exec");
    step(0, 1, OP_R, 6'b000110, 4'd7, K_RWB,     "r.wb");
    step(0, 1, OP_BEQ, 6'd0, 4'd0, K_FGO, "beq.fetch");
    step(0, 1, OP_BEQ, 6'd0, 4'd1, K_DEC, "beq.dec");
    step(0, 0, OP_BEQ, 6'd0, 4'd8, K_BR,  "beq.br");
    step(0, 1, OP_J, 6'd0, 4'd0, K_FGO, "j.fetch");
    step(0, 1, OP_J, 6'd0, 4'd1, K_DEC, "j.dec");
    step(0, 1, OP_J, 6'd0, 4'd9, K_JMP, "j.jump");

    // ANDI
    step(0, 1, OP_ANDI, 6'd0, 4'd0,  K_FGO,   "andi.fetch");
    step(0, 1, OP_ANDI, 6'd0, 4'd1,  K_DEC,   "andi.dec");
    step(0, 1, OP_ANDI, 6'd0, 4'd10, K_IANDI, "andi.exec");
    step(0, 1, OP_ANDI, 6'd0, 4'd11, K_IWB,   "andi.wb");

    // SW with one stall cycle in MEMWR
    step(0, 1, OP_SW, 6'd0, 4'd0, K_FGO,    "sw.fetch");
    step(0, 1, OP_SW, 6'd0, 4'd1, K_DEC,    "sw.dec");
    step(0, 1, OP_SW, 6'd0, 4'd2, K_MADR,   "sw.adr");
    step(0, 0, OP_SW, 6'd0, 4'd5, K_MWWAIT, "sw.wr0");
    step(0, 1, OP_SW, 6'd0, 4'd5, K_MWGO,   "sw.wr1");

    // Illegal opcode: pulse in DECODE, back to FETCH, no count
    step(0, 1, OP_BAD, 6'd0, 4'd0, K_FGO,    "ill.fetch");
    step(0, 1, OP_BAD, 6'd0, 4'd1, K_DECILL, "ill.dec");

    // HALT: sticks for 20 cycles regardless of inputs
    step(0, 1, OP_HALT, 6'd0, 4'd0, K_FGO, "halt.fetch");
    step(0, 1, OP_HALT, 6'd0, 4'd1, K_DEC, "halt.dec");
    for (int i = 0; i < 20; i++) begin
      step(0, i[0], (i[1] ? OP_LW : OP_HALT), 6'd0, 4'd12, K_HALT, "halt.hold");
    end

    // Reset out of HALT, then reset during a stalled store
    step(1, 1, OP_SW, 6'd0, 4'd0, K_NONE,   "rst.halt");
    step(0, 1, OP_SW, 6'd0, 4'd0, K_FGO,    "sw2.fetch");
    step(0, 1, OP_SW, 6'd0, 4'd1, K_DEC,    "sw2.dec");
    step(0, 1, OP_SW, 6'd0, 4'd2, K_MADR,   "sw2.adr");
    step(0, 0, OP_SW, 6'd0, 4'd5, K_MWWAIT, "sw2.wr0");
    step(1, 0, OP_SW, 6'd0, 4'd0, K_NONE,   "sw2.rst");
    step(0, 0, OP_SW, 6'd0, 4'd0, K_FWAIT,  "post.fw");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
